// File: rtl/stack_if.sv
// stack_if: push/pop request and top-of-stack status bundle for stack_unit
interface stack_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
);
  logic              push;
  logic              pop;
  logic              clr_err;
  logic [DATA_W-1:0] push_data;
  logic [DATA_W-1:0] stack_out;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic              overflow;
  logic              underflow;
  modport master (
    output push, pop, clr_err, push_data,
    input  stack_out, count, empty, full, overflow, underflow
  );
  modport slave (
    input  push, pop, clr_err, push_data,
    output stack_out, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: hardware LIFO with registered top of stack and sticky overflow/underflow flags
module stack_unit #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5
) (
  input  logic    clk,
  input  logic    rst_n,
  stack_if.slave  bus
);
  localparam int IW = CNT_W - 1;
  logic [DATA_W-1:0] top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              of_q, of_d, uf_q, uf_d;
  logic              wr_en, is_empty, is_full;
  logic [IW-1:0]     lo, wr_idx, rd_idx;
  logic [DATA_W-1:0] mem_q [DEPTH-1];
  // The top lives in top_q; entry k of mem_q is the (k+1)-th item from the bottom.
  assign is_empty = cnt_q == '0;
  assign is_full  = cnt_q == CNT_W'(DEPTH);
  assign lo       = cnt_q[IW-1:0];
  assign wr_idx   = lo - IW'(1);
  assign rd_idx   = lo - IW'(2);
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    of_d  = of_q & ~bus.clr_err;
    uf_d  = uf_q & ~bus.clr_err;
    wr_en = 1'b0;
    if (bus.push && bus.pop) begin
      top_d = bus.push_data;
      cnt_d = is_empty ? CNT_W'(1) : cnt_q;
      uf_d  = uf_d | is_empty;
    end else if (bus.push) begin
      of_d  = of_d | is_full;
      top_d = is_full ? top_q : bus.push_data;
      cnt_d = is_full ? cnt_q : cnt_q + CNT_W'(1);
      wr_en = !is_full && !is_empty;
    end else if (bus.pop) begin
      uf_d  = uf_d | is_empty;
      top_d = (cnt_q > CNT_W'(1)) ? mem_q[rd_idx] : '0;
      cnt_d = is_empty ? cnt_q : cnt_q - CNT_W'(1);
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
      of_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
      of_q  <= of_d;
      uf_q  <= uf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= top_q;
  end
  assign bus.stack_out = top_q;
  assign bus.count     = cnt_q;
  assign bus.empty     = is_empty;
  assign bus.full      = is_full;
  assign bus.overflow  = of_q;
  assign bus.underflow = uf_q;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed vector table plus hand sequences for fill/overflow and async reset
module tb_stack_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  stack_if #(.DATA_W(16), .CNT_W(5)) s ();
  stack_unit #(.DATA_W(16), .DEPTH(16), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(s));
  always #5 clk = ~clk;
  typedef struct {
    logic        push, pop, clr;
    logic [15:0] d;
    logic [15:0] eo;
    logic [4:0]  ec;
    logic        ee, ef, eof, euf;
  } vec_t;
  vec_t v [20];
  task automatic chk(input string nm, input logic [15:0] o, input logic [4:0] c,
                     input logic e, input logic f, input logic ov, input logic un);
    checks++;
    if ({s.stack_out, s.count, s.empty, s.full, s.overflow, s.underflow} !== {o, c, e, f, ov, un}) begin
      failures++;
      $display("FAIL %s got out=%h cnt=%0d e=%b f=%b of=%b uf=%b exp out=%h cnt=%0d e=%b f=%b of=%b uf=%b",
               nm, s.stack_out, s.count, s.empty, s.full, s.overflow, s.underflow, o, c, e, f, ov, un);
    end
  endtask
  task automatic step(input logic p, input logic q, input logic [15:0] d, input logic c);
    s.push = p; s.pop = q; s.push_data = d; s.clr_err = c;
    @(posedge clk);
    #1;
    s.push = 1'b0; s.pop = 1'b0; s.clr_err = 1'b0;
  endtask
  initial begin
    v[0]  = '{1'b1, 1'b0, 1'b0, 16'h0101, 16'h0101, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[1]  = '{1'b1, 1'b0, 1'b0, 16'h0202, 16'h0202, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    v[2]  = '{1'b1, 1'b0, 1'b0, 16'h0303, 16'h0303, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    v[3]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0202, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    v[4]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0101, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[5]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[7]  = '{1'b0, 1'b0, 1'b0, 16'hxxxx, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[10] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1};
    v[11] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[12] = '{1'b1, 1'b0, 1'b0, 16'h0001, 16'h0001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[13] = '{1'b1, 1'b0, 1'b0, 16'h0002, 16'h0002, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    v[14] = '{1'b1, 1'b1, 1'b0, 16'hBEEF, 16'hBEEF, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0};
    v[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0001, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[16] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    v[17] = '{1'b1, 1'b1, 1'b0, 16'h0077, 16'h0077, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1};
    v[18] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0077, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0};
    v[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    s.push = 1'b0; s.pop = 1'b0; s.clr_err = 1'b0; s.push_data = '0;
    #12;
    chk("reset_hold", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("reset_idle", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(v[i].push, v[i].pop, v[i].d, v[i].clr);
      chk($sformatf("vec%0d", i), v[i].eo, v[i].ec, v[i].ee, v[i].ef, v[i].eof, v[i].euf);
    end
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 16'h1000 + 16'(i), 1'b0);
      chk($sformatf("fill%0d", i), 16'h1000 + 16'(i), 5'(i + 1), 1'b0, i == 15, 1'b0, 1'b0);
    end
    step(1'b1, 1'b1, 16'hCAFE, 1'b0);
    chk("full_replace", 16'hCAFE, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 16'h100F, 1'b0);
    chk("full_restore", 16'h100F, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'hDEAD, 1'b0);
    chk("overflow", 16'h100F, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h4242, 1'b0);
    chk("full_replace_of", 16'h4242, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h100F, 1'b1);
    chk("of_clear", 16'h100F, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d", i), 16'h100F - 16'(i), 5'(16 - i), 1'b0, i == 0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 16'h0, 1'b0);
    end
    chk("drained", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 16'hAAAA, 1'b0);
    step(1'b1, 1'b0, 16'hBBBB, 1'b0);
    step(1'b1, 1'b0, 16'hCCCC, 1'b0);
    chk("pre_reset", 16'hCCCC, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("async_reset", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b1, 16'h0, 1'b0);
    chk("post_reset_pop", 16'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
